// File: rtl/piggy_coin_bank.sv
// Multi-slot coin accumulator: per-slot synchronise + debounce + edge detect,
// saturating denomination adder and a COLLECT/PAID state machine.
module piggy_coin_bank #(
  parameter int                   N_COINS    = 3,
  parameter int                   WIDTH      = 8,
  parameter int                   DEB_CYCLES = 4,
  parameter logic [N_COINS*8-1:0] COIN_VALS  = {8'd10, 8'd5, 8'd1}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_COINS-1:0] coin_in,
  input  logic [WIDTH-1:0]   target,
  input  logic               clear,
  output logic [N_COINS-1:0] coin_pulse,
  output logic [WIDTH-1:0]   total,
  output logic               paid,
  output logic [WIDTH-1:0]   change,
  output logic               overflow,
  output logic               reject
);

  // Sum width covers eight full-scale 8-bit denominations, so it can never wrap.
  localparam int SW = ((WIDTH > 8) ? WIDTH : 8) + 4;
  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] MAX_TOTAL = SW'({WIDTH{1'b1}});

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PAID    = 1'b1
  } state_t;

  logic [N_COINS-1:0] sync1_r;
  logic [N_COINS-1:0] sync2_r;
  logic [N_COINS-1:0] deb_r;
  logic [N_COINS-1:0] deb_d_r;
  logic [N_COINS-1:0] pulse_r;
  logic [CW-1:0]      cnt_r [N_COINS];

  state_t             state_r;
  logic [WIDTH-1:0]   total_r;
  logic [WIDTH-1:0]   change_r;
  logic               paid_r;
  logic               overflow_r;
  logic               reject_r;

  logic [SW-1:0]      add_s;
  logic [SW-1:0]      sum_s;
  logic [WIDTH-1:0]   sat_s;
  logic               clip_s;
  logic               hit_s;

  // Synchroniser, stability counter and debounced level per slot; clear leaves these alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
      deb_r   <= '0;
      for (int i = 0; i < N_COINS; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= coin_in;
      sync2_r <= sync1_r;
      for (int i = 0; i < N_COINS; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (cnt_r[i] == DEB_LAST) begin
            deb_r[i] <= ~deb_r[i];
            cnt_r[i] <= '0;
          end else begin
            cnt_r[i] <= cnt_r[i] + CW'(1);
          end
        end else begin
          cnt_r[i] <= '0;
        end
      end
    end
  end

  // Registered rising-edge detect of the debounced levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_d_r <= '0;
      pulse_r <= '0;
    end else begin
      deb_d_r <= deb_r;
      pulse_r <= deb_r & ~deb_d_r;
    end
  end

  // Add every pulsing slot's denomination at once, then saturate and compare to target.
  always_comb begin
    add_s = '0;
    for (int i = 0; i < N_COINS; i++) begin
      if (pulse_r[i]) begin
        add_s = add_s + SW'(COIN_VALS[8*i +: 8]);
      end else begin
        add_s = add_s;
      end
    end
    sum_s = SW'(total_r) + add_s;
    if (sum_s > MAX_TOTAL) begin
      sat_s  = {WIDTH{1'b1}};
      clip_s = 1'b1;
    end else begin
      sat_s  = sum_s[WIDTH-1:0];
      clip_s = 1'b0;
    end
    hit_s = (target != '0) && (sat_s >= target);
  end

  // Bank state machine; clear outranks both coins and the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= COLLECT;
      total_r    <= '0;
      change_r   <= '0;
      paid_r     <= 1'b0;
      overflow_r <= 1'b0;
      reject_r   <= 1'b0;
    end else if (clear) begin
      state_r    <= COLLECT;
      total_r    <= '0;
      change_r   <= '0;
      paid_r     <= 1'b0;
      overflow_r <= 1'b0;
      reject_r   <= 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          reject_r <= 1'b0;
          total_r  <= sat_s;
          if (clip_s) begin
            overflow_r <= 1'b1;
          end else begin
            overflow_r <= overflow_r;
          end
          if (hit_s) begin
            state_r  <= PAID;
            paid_r   <= 1'b1;
            change_r <= sat_s - target;
          end else begin
            state_r  <= COLLECT;
            paid_r   <= 1'b0;
            change_r <= '0;
          end
        end
        PAID: begin
          // Total and change stay frozen; any arriving coin is bounced back.
          reject_r <= |pulse_r;
        end
        default: begin
          state_r    <= COLLECT;
          total_r    <= '0;
          change_r   <= '0;
          paid_r     <= 1'b0;
          overflow_r <= 1'b0;
          reject_r   <= 1'b0;
        end
      endcase
    end
  end

  assign coin_pulse = pulse_r;
  assign total      = total_r;
  assign paid       = paid_r;
  assign change     = change_r;
  assign overflow   = overflow_r;
  assign reject     = reject_r;

endmodule
